// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed BCD clock display scanner with frame shadowing, setup-field blink and a sticky error flag.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module bcd_display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [1:0] set_field,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       dp,
  output logic       frame,
  output logic       err
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_DIV - 1);

  logic          running;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [FW-1:0] fcnt;
  logic          blink;
  logic [7:0]    sh_hour, sh_minute, sh_second;

  logic          wrap, snap;
  logic [PW-1:0] nxt_presc;
  logic [2:0]    nxt_idx;
  logic [FW-1:0] nxt_fcnt;
  logic          nxt_blink;
  logic [7:0]    nxt_hour, nxt_minute, nxt_second;
  logic [3:0]    nib;
  logic [1:0]    field;
  logic          blank;
  logic [6:0]    seg_d;
  logic [6:0]    enc;

  // The first cycle after reset release starts frame 0 without counting it as a blink frame.
  always_comb begin
    wrap       = (presc == PRESC_MAX);
    snap       = !running || (wrap && idx == 3'd5);
    nxt_presc  = presc + 1'b1;
    nxt_idx    = idx;
    nxt_fcnt   = fcnt;
    nxt_blink  = blink;
    nxt_hour   = sh_hour;
    nxt_minute = sh_minute;
    nxt_second = sh_second;
    if (!running) begin
      nxt_presc = '0;
      nxt_idx   = 3'd0;
    end else if (wrap) begin
      nxt_presc = '0;
      nxt_idx   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    if (snap) begin
      nxt_hour   = hour;
      nxt_minute = minute;
      nxt_second = second;
    end
    if (running && snap) begin
      if (fcnt == FCNT_MAX) begin
        nxt_fcnt  = '0;
        nxt_blink = ~blink;
      end else begin
        nxt_fcnt = fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    nib = 4'd0;
    case (nxt_idx)
      3'd0:    nib = nxt_hour[7:4];
      3'd1:    nib = nxt_hour[3:0];
      3'd2:    nib = nxt_minute[7:4];
      3'd3:    nib = nxt_minute[3:0];
      3'd4:    nib = nxt_second[7:4];
      default: nib = nxt_second[3:0];
    endcase
  end

  always_comb begin
    enc = 7'h40;
    case (nib)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  end

  // Field code of a digit: hours (11) for 0-1, minutes (10) for 2-3, seconds (01) for 4-5.
  always_comb begin
    field = 2'd3 - nxt_idx[2:1];
    blank = nxt_blink && (set_field != 2'b00) && (set_field == field);
    seg_d = enc;
`ifdef LEADING_ZERO_BLANK_EN
    if (nxt_idx == 3'd0 && nib == 4'd0)
      seg_d = 7'h00;
`endif
    if (blank)
      seg_d = 7'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running   <= 1'b0;
      presc     <= '0;
      idx       <= 3'd0;
      fcnt      <= '0;
      blink     <= 1'b0;
      sh_hour   <= 8'h00;
      sh_minute <= 8'h00;
      sh_second <= 8'h00;
      seg       <= 7'h00;
      dig_sel   <= 6'b000000;
      dp        <= 1'b0;
      frame     <= 1'b0;
      err       <= 1'b0;
    end else begin
      running   <= 1'b1;
      presc     <= nxt_presc;
      idx       <= nxt_idx;
      fcnt      <= nxt_fcnt;
      blink     <= nxt_blink;
      sh_hour   <= nxt_hour;
      sh_minute <= nxt_minute;
      sh_second <= nxt_second;
      seg       <= seg_d;
      dig_sel   <= 6'b000001 << nxt_idx;
      dp        <= (nxt_idx == 3'd1) || (nxt_idx == 3'd3);
      frame     <= snap;
      err       <= err | (nib > 4'd9);
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: per-cycle expected outputs are queued per frame and popped each cycle.
module tb_bcd_display_scan;
  localparam int SD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hour = 8'h12, minute = 8'h34, second = 8'h56;
  logic [1:0] set_field = 2'b00;
  logic [6:0] seg;
  logic [5:0] dig_sel;
  logic       dp, frame, err;

  bcd_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .hour(hour), .minute(minute), .second(second),
    .set_field(set_field), .seg(seg), .dig_sel(dig_sel), .dp(dp), .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       frame;
    logic [5:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       err;
  } obs_t;

  obs_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   fidx = 0;
  int   cyc = 0;
  logic err_exp = 1'b0;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check(input obs_t exp, input string tag);
    obs_t obs;
    obs = {frame, dig_sel, seg, dp, err};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed frame=%b dig=%b seg=%h dp=%b err=%b, expected frame=%b dig=%b seg=%h dp=%b err=%b",
             tag, obs.frame, obs.dig, obs.seg, obs.dp, obs.err,
             exp.frame, exp.dig, exp.seg, exp.dp, exp.err);
    end
  endtask

  // Queue one whole frame from the inputs as they stand at its snapshot.
  task automatic push_frame();
    for (int c = 0; c < 6 * SD; c++) begin
      int         d;
      logic [3:0] nib;
      logic [1:0] fld;
      obs_t       e;
      d = c / SD;
      case (d)
        0: nib = hour[7:4];    1: nib = hour[3:0];
        2: nib = minute[7:4];  3: nib = minute[3:0];
        4: nib = second[7:4];  default: nib = second[3:0];
      endcase
      fld = (d < 2) ? 2'b11 : (d < 4) ? 2'b10 : 2'b01;
      e.seg = enc(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 0 && nib == 4'd0) e.seg = 7'h00;
`endif
      if (((fidx / BD) % 2 == 1) && set_field == fld) e.seg = 7'h00;
      if (nib > 4'd9) err_exp = 1'b1;
      e.frame = (c == 0);
      e.dig   = 6'b000001 << d;
      e.dp    = (d == 1) || (d == 3);
      e.err   = err_exp;
      q.push_back(e);
    end
    fidx++;
    cyc = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      obs_t e;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL scoreboard: observed empty queue, expected an entry");
      end else begin
        e = q.pop_front();
        check(e, $sformatf("frame%0d_cyc%0d", fidx - 1, cyc));
      end
      cyc++;
    end
  endtask

  task automatic check_reset(input string tag);
    @(posedge clk);
    #1;
    check('0, tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check('0, "reset_hold");
    check_reset("reset_hold2");

    // Frames 0-2: basic scan, mid-frame input change must not tear
    rst_n = 1'b1;
    push_frame(); step(24);
    push_frame(); step(10);
    second = 8'h57;
    step(14);
    push_frame(); step(24);

    // Frames 3-7: blinking of the field under setup (blank in frames 2-3 of every 4)
    set_field = 2'b01;
    push_frame(); step(24);
    push_frame(); step(24);
    push_frame(); step(24);
    set_field = 2'b10;
    push_frame(); step(24);
    set_field = 2'b11;
    push_frame(); step(24);

    // Frames 8-9: invalid nibble shows dash, error stays sticky after recovery
    set_field = 2'b00;
    second = 8'h5A;
    push_frame(); step(24);
    second = 8'h57;
    push_frame(); step(24);

    // Frame 10: zero in hour tens
    hour = 8'h08;
    push_frame(); step(24);

    // Frame 11: reset during digit 3
    push_frame(); step(14);
    rst_n = 1'b0;
    q.delete();
    check_reset("reset_mid_frame");
    check_reset("reset_mid_frame2");
    err_exp = 1'b0;
    fidx = 0;
    rst_n = 1'b1;
    push_frame(); step(24);
    push_frame(); step(24);

    // Frame 2 after reset: blanked invalid nibble still sets the error flag
    set_field = 2'b01;
    second = 8'h5A;
    push_frame(); step(24);
    second = 8'h34;
    push_frame(); step(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SCAN_DIV, 50000, CLK cycles each digit is held (legal range 2..2^20).
REQ-002 BLINK_DIV, 125, full frames per blink half-period (legal range 1..2^10).
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 HOUR  in  8  packed BCD {tens,units}, hours.
REQ-006 MINUTE  in  8  packed BCD {tens,units}, minutes.
REQ-007 SECOND  in  8  packed BCD {tens,units}, seconds.
REQ-008 SET_FIELD  in  2  field under setup: 00 none, 01 seconds, 10 minutes, 11 hours.
REQ-009 SEG  out  7  segment drive, active high, SEG[0]=a … SEG[6]=g.
REQ-010 DIG_SEL  out  6  one-hot digit enable, active high; bit0 = hour tens … bit5 = second units.
REQ-011 DP  out  1  decimal point, high while digit 1 (hour units) or digit 3 (minute units) is driven.
REQ-012 FRAME  out  1  one-cycle pulse marking a shadow snapshot / frame start.
REQ-013 ERR  out  1  sticky flag: a non-BCD nibble (>9) was displayed.

Function
REQ-014 Prescaler counts 0..SCAN_DIV-1 and wraps; the digit index advances 0..5 on each wrap, then returns from 5 to 0.
REQ-015 On every index change to 0, and on the first cycle after reset release, HOUR/MINUTE/SECOND are copied into shadow registers and FRAME is 1 for that cycle only.
REQ-016 Input changes mid-frame do not affect the display until the next snapshot; no tearing within a frame.
REQ-017 SEG, DIG_SEL and DP are registered and update on the same edge the index changes; each digit holds exactly SCAN_DIV cycles; exactly one DIG_SEL bit is high outside reset.
REQ-018 Digit map: 0=HOUR[7:4], 1=HOUR[3:0], 2=MINUTE[7:4], 3=MINUTE[3:0], 4=SECOND[7:4], 5=SECOND[3:0].
REQ-019 Encoding (hex, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-020 A nibble >9 displays 40 (dash) and sets ERR on the cycle the digit is driven; ERR clears only on reset.
REQ-021 Frame counter counts snapshots 0..BLINK_DIV-1; blink phase toggles on its wrap and starts at 0 after reset.
REQ-022 While blink phase=1, digits of the field selected by SET_FIELD drive SEG=00; DIG_SEL and DP are unaffected; SET_FIELD is sampled live, not shadowed.
REQ-023 Blanking takes priority over the dash; ERR is still set by a blanked invalid nibble.

Reset
REQ-024 While RST_N=0 at a CLK edge: SEG=00, DIG_SEL=000000, DP=0, FRAME=0, ERR=0; prescaler, index, frame counter, blink phase and shadows cleared.
REQ-025 Reset asserted mid-frame takes effect at the next edge; after release the scan restarts at digit 0 per REQ-015.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN: when defined, digit 0 with value 0 drives SEG=00; when undefined, it drives 3F; all other digits are unaffected.

Verification
REQ-027 SCAN_DIV=4, HOUR=12, MINUTE=34, SECOND=56, reset release -> SEG 06,5B,4F,66,6D,7D with DIG_SEL 000001..100000, each held 4 cycles; DP high on digits 1 and 3; FRAME every 24 cycles.
REQ-028 SECOND changes 56->57 mid-frame -> digit 5 still shows 7D that frame and 07 from the next FRAME.
REQ-029 SCAN_DIV=4, BLINK_DIV=2, SET_FIELD=01 -> digits 4,5 SEG=00 during frames 2-3 of every 4; normal in frames 0-1; other digits always normal.
REQ-030 SECOND=8'h5A -> digit 5 SEG=40, ERR=1 and held after SECOND returns valid until RST_N=0.
REQ-031 HOUR=8'h08 -> digit 0 SEG=00 with LEADING_ZERO_BLANK_EN defined, 3F without.
REQ-032 RST_N low during digit 3 -> next edge all outputs at reset values; after release FRAME=1 and digit 0 is driven.
